// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sole owner of the shared main-RAM port. It moves whole 8-word cache lines
//   for the I-cache (refill only) and the D-cache (optional dirty writeback
//   followed by refill). When both caches request in the same cycle, the
//   grant alternates between them.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no transfer; requests are sampled and arbitrated here only
// IC_FILL   | I-line refill, cnt 0..8: read addr out at 0..7, fill at 1..8
// DC_WB     | D victim writeback, cnt 0..7: one RAM write per cycle
// DC_FILL   | D-line refill, cnt 0..8: same timing as IC_FILL
// DONE_IC   | single-cycle ic_done_out pulse
// DONE_DC   | single-cycle dc_done_out pulse
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   ic_req_in, ic_addr_in           I-cache refill request / miss byte address
//   dc_req_in, dc_dirty_in          D-cache miss request / victim is dirty
//   dc_addr_in, dc_wb_addr_in       D miss byte address / victim byte address
//   dc_wdata_in                     victim word read at dc_word_sel_out
//   ram_rdata_in                    RAM read data, one cycle after the address
//   ram_en_out, ram_we_out          RAM enable / write
//   ram_addr_out, ram_wdata_out     RAM word address / write data
//   ic_fill_we_out, ic_word_sel_out I-cache fill strobe / word index
//   ic_fill_data_out, ic_done_out   I-cache fill data / completion pulse
//   dc_fill_we_out, dc_word_sel_out D-cache fill strobe / word index
//   dc_fill_data_out, dc_done_out   D-cache fill data / completion pulse
//   busy_out                        a transfer is in progress
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_in,
  input  logic [ADDR_W-1:0] ic_addr_in,
  input  logic              dc_req_in,
  input  logic              dc_dirty_in,
  input  logic [ADDR_W-1:0] dc_addr_in,
  input  logic [ADDR_W-1:0] dc_wb_addr_in,
  input  logic [DATA_W-1:0] dc_wdata_in,
  input  logic [DATA_W-1:0] ram_rdata_in,
  output logic              ram_en_out,
  output logic              ram_we_out,
  output logic [ADDR_W-3:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_wdata_out,
  output logic              ic_fill_we_out,
  output logic [2:0]        ic_word_sel_out,
  output logic [DATA_W-1:0] ic_fill_data_out,
  output logic              ic_done_out,
  output logic              dc_fill_we_out,
  output logic [2:0]        dc_word_sel_out,
  output logic [DATA_W-1:0] dc_fill_data_out,
  output logic              dc_done_out,
  output logic              busy_out
);

  localparam int LINE_W = ADDR_W - 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IC_FILL = 3'd1,
    S_DC_WB   = 3'd2,
    S_DC_FILL = 3'd3,
    S_DONE_IC = 3'd4,
    S_DONE_DC = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_dc_q, last_dc_d;
  logic [LINE_W-1:0] ic_line_q, ic_line_d;
  logic [LINE_W-1:0] dc_line_q, dc_line_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;

  logic              grant_ic;
  logic              grant_dc;
  logic [3:0]        cnt_m1;
  logic              fill_rd;
  logic              fill_wr;

  // Byte-offset bits inside a line play no part in whole-line transfers.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{ic_addr_in[4:0], dc_addr_in[4:0], dc_wb_addr_in[4:0]};

  // On a tie the requester that was not served last wins; reset leaves
  // last_dc_q set so the first tie goes to the I-cache.
  assign grant_ic = ic_req_in & (~dc_req_in | last_dc_q);
  assign grant_dc = dc_req_in & (~ic_req_in | ~last_dc_q);

  // Fill timing: the address goes out at cnt 0..7 and the data comes back one
  // cycle later, so the cache write for word k happens at cnt k+1.
  assign cnt_m1  = cnt_q - 4'd1;
  assign fill_rd = ~cnt_q[3];
  assign fill_wr = (cnt_q != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      last_dc_q <= 1'b1;
      ic_line_q <= '0;
      dc_line_q <= '0;
      wb_line_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_dc_q <= last_dc_d;
      ic_line_q <= ic_line_d;
      dc_line_q <= dc_line_d;
      wb_line_q <= wb_line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_dc_d = last_dc_q;
    ic_line_d = ic_line_q;
    dc_line_d = dc_line_q;
    wb_line_d = wb_line_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_ic) begin
          state_d   = S_IC_FILL;
          cnt_d     = 4'd0;
          last_dc_d = 1'b0;
          ic_line_d = ic_addr_in[ADDR_W-1:5];
        end else if (grant_dc) begin
          state_d   = dc_dirty_in ? S_DC_WB : S_DC_FILL;
          cnt_d     = 4'd0;
          last_dc_d = 1'b1;
          dc_line_d = dc_addr_in[ADDR_W-1:5];
          wb_line_d = dc_wb_addr_in[ADDR_W-1:5];
        end
      end

      S_IC_FILL: begin
        if (cnt_q == 4'd8) begin
          state_d = S_DONE_IC;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // Writeback runs straight into the refill with no re-arbitration.
      S_DC_WB: begin
        if (cnt_q == 4'd7) begin
          state_d = S_DC_FILL;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DC_FILL: begin
        if (cnt_q == 4'd8) begin
          state_d = S_DONE_DC;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE_IC: state_d = S_IDLE;
      S_DONE_DC: state_d = S_IDLE;

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control outputs are decoded from state/cnt only.
  always_comb begin
    ram_en_out      = 1'b0;
    ram_we_out      = 1'b0;
    ram_addr_out    = '0;
    ic_fill_we_out  = 1'b0;
    ic_word_sel_out = 3'd0;
    ic_done_out     = 1'b0;
    dc_fill_we_out  = 1'b0;
    dc_word_sel_out = 3'd0;
    dc_done_out     = 1'b0;

    unique case (state_q)
      S_IC_FILL: begin
        ram_en_out = fill_rd;
        if (fill_rd) begin
          ram_addr_out = {ic_line_q, cnt_q[2:0]};
        end
        ic_fill_we_out = fill_wr;
        if (fill_wr) begin
          ic_word_sel_out = cnt_m1[2:0];
        end
      end

      S_DC_WB: begin
        ram_en_out      = 1'b1;
        ram_we_out      = 1'b1;
        ram_addr_out    = {wb_line_q, cnt_q[2:0]};
        dc_word_sel_out = cnt_q[2:0];
      end

      S_DC_FILL: begin
        ram_en_out = fill_rd;
        if (fill_rd) begin
          ram_addr_out = {dc_line_q, cnt_q[2:0]};
        end
        dc_fill_we_out = fill_wr;
        if (fill_wr) begin
          dc_word_sel_out = cnt_m1[2:0];
        end
      end

      S_DONE_IC: ic_done_out = 1'b1;
      S_DONE_DC: dc_done_out = 1'b1;

      default: begin
      end
    endcase
  end

  assign busy_out         = (state_q != S_IDLE);
  assign ram_wdata_out    = dc_wdata_in;
  assign ic_fill_data_out = ram_rdata_in;
  assign dc_fill_data_out = ram_rdata_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ic_req_in;
  logic [ADDR_W-1:0] ic_addr_in;
  logic              dc_req_in;
  logic              dc_dirty_in;
  logic [ADDR_W-1:0] dc_addr_in;
  logic [ADDR_W-1:0] dc_wb_addr_in;
  logic [DATA_W-1:0] dc_wdata_in;
  logic [DATA_W-1:0] ram_rdata_in = '0;
  logic              ram_en_out;
  logic              ram_we_out;
  logic [ADDR_W-3:0] ram_addr_out;
  logic [DATA_W-1:0] ram_wdata_out;
  logic              ic_fill_we_out;
  logic [2:0]        ic_word_sel_out;
  logic [DATA_W-1:0] ic_fill_data_out;
  logic              ic_done_out;
  logic              dc_fill_we_out;
  logic [2:0]        dc_word_sel_out;
  logic [DATA_W-1:0] dc_fill_data_out;
  logic              dc_done_out;
  logic              busy_out;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ic_req_in        (ic_req_in),
    .ic_addr_in       (ic_addr_in),
    .dc_req_in        (dc_req_in),
    .dc_dirty_in      (dc_dirty_in),
    .dc_addr_in       (dc_addr_in),
    .dc_wb_addr_in    (dc_wb_addr_in),
    .dc_wdata_in      (dc_wdata_in),
    .ram_rdata_in     (ram_rdata_in),
    .ram_en_out       (ram_en_out),
    .ram_we_out       (ram_we_out),
    .ram_addr_out     (ram_addr_out),
    .ram_wdata_out    (ram_wdata_out),
    .ic_fill_we_out   (ic_fill_we_out),
    .ic_word_sel_out  (ic_word_sel_out),
    .ic_fill_data_out (ic_fill_data_out),
    .ic_done_out      (ic_done_out),
    .dc_fill_we_out   (dc_fill_we_out),
    .dc_word_sel_out  (dc_word_sel_out),
    .dc_fill_data_out (dc_fill_data_out),
    .dc_done_out      (dc_done_out),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  // RAM contents are a fixed function of the word address.
  function automatic logic [31:0] rd_fn(input logic [29:0] a);
    return {a[15:0] ^ 16'h5AA5, a[15:0]};
  endfunction

  // Victim word pattern presented by the D-cache for a given word index.
  function automatic logic [31:0] wd_fn(input logic [2:0] s);
    return 32'hD00D_0000 | {29'd0, s} | ({29'd0, s} << 8);
  endfunction

  function automatic logic [26:0] line_of(input logic [31:0] a);
    return a[31:5];
  endfunction

  assign dc_wdata_in = wd_fn(dc_word_sel_out);

  always @(posedge clk) begin
    if (ram_en_out && !ram_we_out) ram_rdata_in <= rd_fn(ram_addr_out);
  end

  typedef struct packed {
    logic        en;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        ic_we;
    logic [2:0]  ic_sel;
    logic [31:0] ic_data;
    logic        ic_done;
    logic        dc_we;
    logic [2:0]  dc_sel;
    logic [31:0] dc_data;
    logic        dc_done;
    logic        busy;
  } rec_t;

  rec_t sb[$];

  function automatic void push_idle();
    rec_t r;
    r = '0;
    sb.push_back(r);
  endfunction

  function automatic void push_fill(input bit is_dc, input logic [26:0] line);
    rec_t r;
    logic [2:0] w;
    for (int k = 0; k <= 8; k++) begin
      r = '0;
      r.busy = 1'b1;
      if (k <= 7) begin
        w = 3'(k);
        r.en = 1'b1;
        r.addr = {line, w};
      end
      if (k >= 1) begin
        w = 3'(k - 1);
        if (is_dc) begin
          r.dc_we = 1'b1; r.dc_sel = w; r.dc_data = rd_fn({line, w});
        end else begin
          r.ic_we = 1'b1; r.ic_sel = w; r.ic_data = rd_fn({line, w});
        end
      end
      sb.push_back(r);
    end
    r = '0;
    r.busy = 1'b1;
    if (is_dc) r.dc_done = 1'b1;
    else       r.ic_done = 1'b1;
    sb.push_back(r);
  endfunction

  function automatic void push_wb(input logic [26:0] line, input int n);
    rec_t r;
    logic [2:0] w;
    for (int k = 0; k < n; k++) begin
      w = 3'(k);
      r = '0;
      r.busy = 1'b1;
      r.en = 1'b1;
      r.we = 1'b1;
      r.addr = {line, w};
      r.dc_sel = w;
      r.wdata = wd_fn(w);
      sb.push_back(r);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared in full; any
  // activity with nothing expected is an error.
  always @(negedge clk) begin
    rec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("busy",       32'(busy_out),       32'(e.busy));
      chk("ram_en",     32'(ram_en_out),     32'(e.en));
      chk("ram_we",     32'(ram_we_out),     32'(e.we));
      chk("ic_fill_we", 32'(ic_fill_we_out), 32'(e.ic_we));
      chk("dc_fill_we", 32'(dc_fill_we_out), 32'(e.dc_we));
      chk("ic_done",    32'(ic_done_out),    32'(e.ic_done));
      chk("dc_done",    32'(dc_done_out),    32'(e.dc_done));
      if (e.en) chk("ram_addr", 32'(ram_addr_out), 32'(e.addr));
      if (e.we) chk("ram_wdata", ram_wdata_out, e.wdata);
      if (e.ic_we) begin
        chk("ic_word_sel", 32'(ic_word_sel_out), 32'(e.ic_sel));
        chk("ic_fill_data", ic_fill_data_out, e.ic_data);
      end
      if (e.dc_we || e.we) chk("dc_word_sel", 32'(dc_word_sel_out), 32'(e.dc_sel));
      if (e.dc_we) chk("dc_fill_data", dc_fill_data_out, e.dc_data);
    end else if (ram_en_out || ic_fill_we_out || dc_fill_we_out ||
                 ic_done_out || dc_done_out || busy_out) begin
      checks++;
      failures++;
      $display("FAIL unexpected_activity: en=%b we=%b icwe=%b dcwe=%b icdone=%b dcdone=%b busy=%b expected all 0 at %0t",
               ram_en_out, ram_we_out, ic_fill_we_out, dc_fill_we_out,
               ic_done_out, dc_done_out, busy_out, $time);
    end
  end

  // Requester side: drop the request on the cycle its done pulse is seen.
  task automatic wait_done(input bit is_dc, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (is_dc ? dc_done_out : ic_done_out) begin
        seen = 1'b1;
        if (is_dc) dc_req_in = 1'b0;
        else       ic_req_in = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: %s done not seen within %0d cycles, required 1", is_dc ? "dc" : "ic", budget);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    32'(busy_out),        32'd0);
    chk({tag, "_ram_en"},  32'(ram_en_out),      32'd0);
    chk({tag, "_ram_we"},  32'(ram_we_out),      32'd0);
    chk({tag, "_ram_addr"},32'(ram_addr_out),    32'd0);
    chk({tag, "_ic_we"},   32'(ic_fill_we_out),  32'd0);
    chk({tag, "_dc_we"},   32'(dc_fill_we_out),  32'd0);
    chk({tag, "_ic_sel"},  32'(ic_word_sel_out), 32'd0);
    chk({tag, "_dc_sel"},  32'(dc_word_sel_out), 32'd0);
    chk({tag, "_ic_done"}, 32'(ic_done_out),     32'd0);
    chk({tag, "_dc_done"}, 32'(dc_done_out),     32'd0);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ic_req_in = 1'b0; ic_addr_in = '0;
    dc_req_in = 1'b0; dc_dirty_in = 1'b0; dc_addr_in = '0; dc_wb_addr_in = '0;
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Tie right after reset: IC first; IC re-requests while DC waits, DC next.
    @(posedge clk); #1;
    ic_req_in = 1'b1; ic_addr_in = 32'h0000_1040;
    dc_req_in = 1'b1; dc_dirty_in = 1'b0; dc_addr_in = 32'h0000_2000;
    push_idle();
    push_fill(1'b0, line_of(32'h0000_1040));
    push_idle();
    push_fill(1'b1, line_of(32'h0000_2000));
    push_idle();
    push_fill(1'b0, line_of(32'h0000_1060));
    wait_done(1'b0, 40);
    @(posedge clk); #1;
    ic_req_in = 1'b1; ic_addr_in = 32'h0000_1060;
    wait_done(1'b1, 40);
    wait_done(1'b0, 40);

    // Dirty D miss; request dropped mid-writeback must not stop the transfer.
    @(posedge clk); #1;
    dc_req_in = 1'b1; dc_dirty_in = 1'b1;
    dc_wb_addr_in = 32'h0000_3020; dc_addr_in = 32'h0000_4000;
    push_idle();
    push_wb(line_of(32'h0000_3020), 8);
    push_fill(1'b1, line_of(32'h0000_4000));
    repeat (4) @(negedge clk);
    #1 dc_req_in = 1'b0; dc_dirty_in = 1'b0;
    wait_done(1'b1, 40);

    // Reset during writeback word 4, then re-grant from the start.
    @(posedge clk); #1;
    dc_req_in = 1'b1; dc_dirty_in = 1'b1;
    dc_wb_addr_in = 32'h0000_5000; dc_addr_in = 32'h0000_6020;
    push_idle();
    push_wb(line_of(32'h0000_5000), 5);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_idle();
    push_wb(line_of(32'h0000_5000), 8);
    push_fill(1'b1, line_of(32'h0000_6020));
    wait_done(1'b1, 40);

    // DC request arriving during IC_FILL cnt=3 waits for the IC transfer.
    @(posedge clk); #1;
    ic_req_in = 1'b1; ic_addr_in = 32'h0000_7FE0; dc_dirty_in = 1'b0;
    push_idle();
    push_fill(1'b0, line_of(32'h0000_7FE0));
    repeat (5) @(negedge clk);
    #1 dc_req_in = 1'b1; dc_addr_in = 32'h0000_80A0;
    push_idle();
    push_fill(1'b1, line_of(32'h0000_80A0));
    wait_done(1'b0, 40);
    wait_done(1'b1, 40);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequential owner of the single shared main-RAM port.
- Serves 8-word line transfers for the instruction cache (refill only) and the data cache (dirty writeback, then refill).
- Holds the FSM state and word counter, arbitrates I/D requests round-robin, and drives the RAM and cache fill/writeback strobes.
- Sits between both cache arrays and the RAM.

Parameters:
- ADDR_W, 32, byte-address width; line address is addr[ADDR_W-1:5]; RAM word address is ADDR_W-2 bits.
- DATA_W, 32, RAM and cache word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic_req_in  in  1  I-cache refill request; level, held until ic_done_out.
- ic_addr_in  in  ADDR_W  I-cache miss byte address.
- dc_req_in  in  1  D-cache miss request; level, held until dc_done_out.
- dc_dirty_in  in  1  victim line is dirty; writeback required before refill.
- dc_addr_in  in  ADDR_W  D-cache miss byte address.
- dc_wb_addr_in  in  ADDR_W  victim line byte address.
- dc_wdata_in  in  DATA_W  victim word; combinational cache read at dc_word_sel_out.
- ram_rdata_in  in  DATA_W  RAM read data; synchronous, 1-cycle latency.
- ram_en_out  out  1  RAM enable.
- ram_we_out  out  1  RAM write.
- ram_addr_out  out  ADDR_W-2  RAM word address.
- ram_wdata_out  out  DATA_W  RAM write data (= dc_wdata_in).
- ic_fill_we_out  out  1  I-cache word write strobe.
- ic_word_sel_out  out  3  I-cache word index for the fill.
- ic_fill_data_out  out  DATA_W  fill data (= ram_rdata_in).
- ic_done_out  out  1  one-cycle completion pulse.
- dc_fill_we_out  out  1  D-cache word write strobe; cache sets valid=1, dirty=0.
- dc_word_sel_out  out  3  D-cache word index (writeback read or fill write).
- dc_fill_data_out  out  DATA_W  fill data (= ram_rdata_in).
- dc_done_out  out  1  one-cycle completion pulse.
- busy_out  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, last_grant=DC, latched addresses=0.
  - All strobes, done and busy outputs are 0; word selects are 0.
  - Reset mid-transfer abandons the transfer: no done pulse, partial line left as written.
- Outputs depend only on the state/cnt registers, except the data pass-throughs ram_wdata_out, ic_fill_data_out and dc_fill_data_out.
- States: IDLE, IC_FILL, DC_WB, DC_FILL, DONE_IC, DONE_DC.
- IDLE:
  - Requests are sampled only here.
  - If only one request is high, grant it. If both are high, grant the requester other than last_grant, so the first tie after reset goes to IC.
  - On grant: latch the line addresses, set cnt=0, update last_grant.
  - IC grant goes to IC_FILL. DC grant goes to DC_WB if dc_dirty_in=1, else DC_FILL.
- IC_FILL / DC_FILL, cnt=0..8 (9 cycles):
  - ram_en=1, ram_we=0 and ram_addr={line,cnt[2:0]} while cnt<=7.
  - fill_we=1 and word_sel=cnt-1 while cnt>=1.
  - At cnt=8, move to DONE_x.
- DC_WB, cnt=0..7 (8 cycles):
  - ram_en=1, ram_we=1, ram_addr={wb_line,cnt}, dc_word_sel_out=cnt, ram_wdata=dc_wdata_in.
  - At cnt=7, move to DC_FILL with cnt=0; no intermediate IDLE, no re-arbitration.
- DONE_x: done_out=1 for exactly one cycle, then IDLE.
  - The requester must drop its req on the same edge, so IDLE never re-grants a finished request.
- Latency from grant:
  - Clean miss: 9 cycles of transfer, done pulse in cycle 10.
  - Dirty D miss: 17 cycles, done pulse in cycle 18.
- A request arriving while busy waits. A deasserted request while granted is ignored; the transfer completes.
- cnt is 4 bits. The word index wraps only within a line; the line address never increments.
- ic_* and dc_* strobes are never active in the same cycle.

Test Plan:
- IC miss, ic_addr=0x0000_1040: ram_addr 0x410..0x417 on cycles 0..7; ic_fill_we on cycles 1..8 with word_sel 0..7; data matches RAM; ic_done on cycle 9; busy for 10 cycles.
- Clean DC miss, dc_addr=0x2000: ram_we never asserted; dc_fill_we with word_sel 0..7 at RAM addresses 0x800..0x807; dc_done on cycle 9.
- Dirty DC miss, wb_addr=0x3020, dc_addr=0x4000:
  - 8 writes to 0xC08..0xC0F carrying dc_wdata for word_sel 0..7;
  - then reads from 0x1000..0x1007;
  - dc_done on cycle 17; no idle cycle between writeback and fill.
- ic_req and dc_req raised together right after reset: IC served first. Both raised again: DC served first. Each done pulse appears once.
- rst_n pulled low at DC_WB cnt=4: all outputs 0 asynchronously, no done pulse; after release with dc_req still high, DC is re-granted from cnt=0.
- dc_req arrives during IC_FILL cnt=3: waits; granted the cycle after ic_done; no overlapping strobes.
